ireg_skew: RTL and testbench
============================

Name: ireg_skew

Overview:
- Parametrised successor to the single-register horizontal border buffer.
- Feeds LANES parallel rows of a systolic array edge; each lane carries a WIDTH-bit data word plus a valid bit.
- Lane k is delayed by 1 + k*STEP enabled cycles, which produces the diagonal input skew the array needs.
- Shared enable and synchronous clear; a busy flag reports in-flight valid data for drain control.

Parameters:
- WIDTH, 8, data bits per lane.
- LANES, 4, number of lanes (>=1).
- STEP, 1, extra register stages added per lane index (>=0; 0 gives a uniform 1-cycle buffer on every lane).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance: all lane stages shift when high.
- clr  input  1  synchronous clear of all stages; priority over en.
- i_valid  input  1  valid tag applied to all lanes at entry.
- i_data  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- o_valid  output  LANES  valid bit at the tail of each lane.
- o_data  output  LANES*WIDTH  tail data of each lane, same packing as i_data.
- o_busy  output  1  high while any stage in any lane holds valid=1.

Behaviour:
- Lane k depth D(k) = 1 + k*STEP registers; each register holds {valid, data}.
- Reset (rst_n low, asynchronous): every stage clears to valid=0, data=0. o_valid=0, o_data=0, o_busy=0 immediately, without waiting for a clock edge.
- Per rising edge, with priority order:
  - clr=1: all stages load 0, regardless of en.
  - else en=1: stage 0 of each lane loads {i_valid, lane slice of i_data}; stage j loads stage j-1.
  - else: hold all stages.
- Latency: a word accepted on an enabled edge appears at lane k's output after exactly D(k) enabled edges. Disabled cycles stall the whole structure uniformly, so the skew between lanes is preserved.
- Data registers load even when i_valid=0. Downstream must use o_valid; data is not gated (see optional feature).
- o_busy = OR of all stage valid bits, taken combinationally from registers with no added latency. It falls on the edge after the last valid bit leaves the longest lane.
- clr and en in the same cycle: clr wins, and the input word is discarded.
- STEP=0 or LANES=1: degenerates to a per-lane single register with the same en/clr semantics.
- Reset mid-stream discards all in-flight data with no partial outputs.
- Total flop count: sum over k of D(k)*(WIDTH+1).

Optional Feature:
- Macro: IREG_SKEW_ZERO_GATE_EN.
- Defined: o_data for lane k is forced to 0 whenever o_valid[k]=0, using a combinational AND at the tail. This suppresses toggling into unary/rate-coded PEs.
- Undefined: o_data is the raw tail register contents.
- o_valid and o_busy behave identically in both builds.

Decomposition:
- Package ireg_pkg:
  - function lane_depth(k, STEP) returning 1 + k*STEP.
  - function total_stages(LANES, STEP) for assertions and coverage.
- Sub-module ireg_skew_lane, parameters WIDTH and DEPTH:
  - one lane's shift chain with en/clr.
  - outputs tail {valid, data} and an any-valid flag.
- Top instantiates LANES copies in a generate loop and ORs the any-valid flags into o_busy.

Test Plan:
- Reset: hold rst_n low, drive i_data all ones and i_valid=1 with en=1 -> o_valid=0, o_data=0, o_busy=0 throughout. After release, first valid output on lane 0 appears 1 edge after the first enabled edge.
- Skew (WIDTH=8, LANES=4, STEP=1): en=1, one-cycle pulse i_valid=1 with lanes {0x11,0x22,0x33,0x44} -> lane k shows valid with its value exactly 1+k edges later (edges 1, 2, 3, 4). o_busy is high from edge 1 through edge 4 and low after edge 5.
- Stall: same pulse, then en=0 for 3 cycles after edge 2 -> lanes 2/3 emit at enabled edges 3/4. Outputs hold during the stall; skew is unchanged.
- Clear priority: stream valid words, then assert clr=1 with en=1 mid-stream -> all o_valid=0 and o_data=0 on the next edge, o_busy=0, and the input word on that edge never appears.
- Invalid data: i_valid=0 with i_data=0xAB on all lanes -> o_valid stays 0. o_data equals 0xAB at the tails without the macro, and 0 with IREG_SKEW_ZERO_GATE_EN defined.
- Async reset mid-stream: drop rst_n between edges while o_busy=1 -> outputs go to 0 before the next edge, and no residual valid bits appear after release.

Source files
------------

// File: rtl/ireg_skew_pkg.sv
// Shared helpers for the skewed input-register buffer: per-lane depth and total stage count.
package ireg_pkg;

  function automatic int unsigned lane_depth(input int unsigned k, input int unsigned step);
    return 1 + k * step;
  endfunction

  function automatic int unsigned total_stages(input int unsigned lanes, input int unsigned step);
    int unsigned s;
    s = 0;
    for (int unsigned k = 0; k < lanes; k++) s += lane_depth(k, step);
    return s;
  endfunction

endpackage

// File: rtl/ireg_skew_lane.sv
// One lane of the skew buffer: a DEPTH-stage {valid,data} shift chain with shared en/clr.
module ireg_skew_lane
  import ireg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             tail_valid,
  output logic [WIDTH-1:0] tail_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) dat[j] <= '0;
    end else if (clr) begin
      vld <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) dat[j] <= '0;
    end else if (en) begin
      // Data loads regardless of in_valid; consumers qualify with the valid bit.
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int unsigned j = 1; j < DEPTH; j++) begin
        vld[j] <= vld[j-1];
        dat[j] <= dat[j-1];
      end
    end
  end

  assign tail_valid = vld[DEPTH-1];
  assign tail_data  = dat[DEPTH-1];
  assign any_valid  = |vld;

endmodule

// File: rtl/ireg_skew.sv
// Diagonal input skew for a systolic array edge: lane k delayed by 1 + k*STEP enabled cycles.
// Build option IREG_SKEW_ZERO_GATE_EN forces tail data to zero when the tail is not valid.
module ireg_skew
  import ireg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   i_valid,
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic [LANES-1:0]       o_valid,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic                   o_busy
);

  logic [LANES-1:0]       lane_busy;
  logic [LANES*WIDTH-1:0] tail_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ireg_skew_lane #(
      .WIDTH (WIDTH),
      .DEPTH (lane_depth(k, STEP))
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clr        (clr),
      .in_valid   (i_valid),
      .in_data    (i_data[k*WIDTH +: WIDTH]),
      .tail_valid (o_valid[k]),
      .tail_data  (tail_data[k*WIDTH +: WIDTH]),
      .any_valid  (lane_busy[k])
    );

`ifdef IREG_SKEW_ZERO_GATE_EN
    assign o_data[k*WIDTH +: WIDTH] = tail_data[k*WIDTH +: WIDTH] & {WIDTH{o_valid[k]}};
`endif
  end

`ifndef IREG_SKEW_ZERO_GATE_EN
  assign o_data = tail_data;
`endif

  assign o_busy = |lane_busy;

endmodule

// File: tb/tb_ireg_skew.sv
// Directed self-checking bench for ireg_skew (WIDTH=8, LANES=4, STEP=1) with an expected-output queue.
module tb_ireg_skew;

  localparam int W = 8;
  localparam int L = 4;
  localparam int S = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en, clr, i_valid;
  logic [L*W-1:0] i_data;
  logic [L-1:0]   o_valid;
  logic [L*W-1:0] o_data;
  logic           o_busy;

  ireg_skew #(.WIDTH(W), .LANES(L), .STEP(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    int         due;
    logic       v;
    logic [W-1:0] d;
  } exp_t;

  exp_t q[$];
  int   en_cnt = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_data"},  o_data,       32'h0);
    chk({tag, "_busy"},  32'(o_busy),  32'h0);
  endtask

  task automatic check_due();
    int i;
    logic [W-1:0] ed;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due == en_cnt) begin
`ifdef IREG_SKEW_ZERO_GATE_EN
        ed = q[i].v ? q[i].d : '0;
`else
        ed = q[i].d;
`endif
        chk($sformatf("lane%0d_valid_e%0d", q[i].lane, en_cnt), 32'(o_valid[q[i].lane]), 32'(q[i].v));
        chk($sformatf("lane%0d_data_e%0d", q[i].lane, en_cnt), 32'(o_data[q[i].lane*W +: W]), 32'(ed));
        q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // Drive one cycle, sample 1 time unit after the edge, update the scoreboard.
  task automatic cycle(input logic e, input logic c, input logic v, input logic [L*W-1:0] d);
    exp_t x;
    en = e; clr = c; i_valid = v; i_data = d;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      chk_idle("clr");
    end else if (e) begin
      en_cnt++;
      for (int k = 0; k < L; k++) begin
        x.lane = k;
        x.due  = en_cnt + k * S;
        x.v    = v;
        x.d    = d[k*W +: W];
        q.push_back(x);
      end
      check_due();
    end
  endtask

  initial begin
    logic [31:0] inval;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; i_valid = 1'b1; i_data = '1;

    // Reset held: inputs active, outputs must stay zero.
    #1 chk_idle("rst_t1");
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("rst_hold%0d", n));
    end
    rst_n = 1'b1;

    // Skew: single pulse, lane k valid after 1+k edges; busy high edges 1..4.
    cycle(1'b1, 1'b0, 1'b1, 32'h44332211);
    chk("skew_busy_e1", 32'(o_busy), 32'h1);
    for (int n = 2; n <= 5; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("skew_busy_e%0d", n), 32'(o_busy), (n <= 4) ? 32'h1 : 32'h0);
    end

    // Stall after second enabled edge: outputs hold, skew preserved.
    cycle(1'b1, 1'b0, 1'b1, 32'h44332211);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_l1_valid", 32'(o_valid), 32'h2);
      chk("stall_l1_data", 32'(o_data[W +: W]), 32'h22);
      chk("stall_busy", 32'(o_busy), 32'h1);
    end
    for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_busy_drained", 32'(o_busy), 32'h0);

    // Clear priority over en mid-stream; the word on the clear edge never emerges.
    cycle(1'b1, 1'b0, 1'b1, 32'hA0B0C0D0);
    cycle(1'b1, 1'b0, 1'b1, 32'hA1B1C1D1);
    chk("clr_pre_busy", 32'(o_busy), 32'h1);
    cycle(1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    for (int n = 0; n < 5; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("clr_post_valid%0d", n), 32'(o_valid), 32'h0);
    end

    // Invalid data still loads; gated build zeroes the tails.
    for (int n = 0; n < 4; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'hABABABAB);
      chk($sformatf("inval_valid%0d", n), 32'(o_valid), 32'h0);
    end
`ifdef IREG_SKEW_ZERO_GATE_EN
    inval = 32'h0;
`else
    inval = 32'hABABABAB;
`endif
    chk("inval_tail_data", o_data, inval);
    chk("inval_busy", 32'(o_busy), 32'h0);

    // Asynchronous reset between edges while busy.
    cycle(1'b1, 1'b0, 1'b1, 32'h55667788);
    cycle(1'b1, 1'b0, 1'b1, 32'h55667788);
    chk("arst_pre_busy", 32'(o_busy), 32'h1);
    #3 rst_n = 1'b0;
    #1 chk_idle("arst_async");
    q.delete();
    #1 rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("arst_post_valid%0d", n), 32'(o_valid), 32'h0);
    end
    chk("arst_post_busy", 32'(o_busy), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
